// File: rtl/output_slew_limiter.sv
// rtl/output_slew_limiter.sv - rate-limited DAC drive with hold, park-to-zero ramp and rail-hit counter
module output_slew_limiter #(
  parameter int WIDTH          = 14,
  parameter int STEP_WIDTH     = 13,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk64,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   inputWire,
  input  logic                      enable,
  input  logic                      hold,
  input  logic [STEP_WIDTH-1:0]     maxStep,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic signed [WIDTH-1:0]   outputWire,
  output logic                      slewing,
  output logic [1:0]                state,
  output logic [15:0]               railHits
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_PARK  = 2'd3;

  localparam logic signed [WIDTH-1:0] RAIL_HI = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] RAIL_LO = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0]   r_out;
  logic                      r_slewing;
  logic [1:0]                r_state;
  logic [15:0]               r_rail_hits;
  logic [PRESCALE_WIDTH-1:0] r_pre_cnt;

  logic                      w_tick;
  logic signed [WIDTH-1:0]   w_target;
  logic signed [WIDTH:0]     w_out_ext;
  logic signed [WIDTH:0]     w_diff;
  logic [WIDTH:0]            w_abs_diff;
  logic [WIDTH:0]            w_step_ext;
  logic                      w_within;
  logic signed [WIDTH:0]     w_stepped;
  logic signed [WIDTH-1:0]   w_next_out;
  logic [1:0]                w_nxt_state;
  logic                      w_apply;
  logic                      w_on_rail;

  assign w_tick = (r_pre_cnt == '0);

  // Step rule: one extra bit of headroom so target - output never wraps.
  // The clamped result always sits between the old output and the target,
  // so truncating back to WIDTH bits is lossless.
  assign w_target   = (r_state == ST_PARK) ? '0 : inputWire;
  assign w_out_ext  = {r_out[WIDTH-1], r_out};
  assign w_diff     = {w_target[WIDTH-1], w_target} - w_out_ext;
  assign w_abs_diff = w_diff[WIDTH] ? (0 - w_diff) : w_diff;
  assign w_step_ext = {{(WIDTH+1-STEP_WIDTH){1'b0}}, maxStep};
  assign w_within   = (maxStep == '0) || (w_abs_diff <= w_step_ext);
  assign w_stepped  = w_diff[WIDTH] ? (w_out_ext - $signed(w_step_ext))
                                    : (w_out_ext + $signed(w_step_ext));
  assign w_next_out = w_within ? w_target : w_stepped[WIDTH-1:0];
  assign w_on_rail  = (w_next_out == RAIL_HI) || (w_next_out == RAIL_LO);

  // Next-state and update-enable decode; enable=0 beats hold beats tick.
  always_comb begin
    w_nxt_state = r_state;
    w_apply     = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (enable) w_nxt_state = ST_TRACK;
      end
      ST_TRACK: begin
        if (!enable)     w_nxt_state = ST_PARK;
        else if (hold)   w_nxt_state = ST_HOLD;
        else if (w_tick) w_apply     = 1'b1;
      end
      ST_HOLD: begin
        if (!enable)     w_nxt_state = ST_PARK;
        else if (!hold)  w_nxt_state = ST_TRACK;
      end
      default: begin
        if (enable)                w_nxt_state = ST_TRACK;
        else if (r_out == '0)      w_nxt_state = ST_OFF;
        else if (w_tick) begin
          w_apply = 1'b1;
          if (w_next_out == '0) w_nxt_state = ST_OFF;
        end
      end
    endcase
  end

  // Free-running update prescaler; a new period is picked up at reload.
  always_ff @(posedge clk64 or posedge reset) begin
    if (reset)       r_pre_cnt <= '0;
    else if (w_tick) r_pre_cnt <= prescale;
    else             r_pre_cnt <= r_pre_cnt - 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk64 or posedge reset) begin
    if (reset) r_state <= ST_OFF;
    else       r_state <= w_nxt_state;
  end

  // Output and slewing flag; OFF forces both to zero.
  always_ff @(posedge clk64 or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_slewing <= 1'b0;
    end else if (w_nxt_state == ST_OFF) begin
      r_out     <= '0;
      r_slewing <= 1'b0;
    end else if (w_apply) begin
      r_out     <= w_next_out;
      r_slewing <= ~w_within;
    end
  end

  // Saturating count of tracking updates that land on either rail.
  always_ff @(posedge clk64 or posedge reset) begin
    if (reset)
      r_rail_hits <= '0;
    else if (w_apply && (r_state == ST_TRACK) && w_on_rail && (r_rail_hits != 16'hFFFF))
      r_rail_hits <= r_rail_hits + 16'd1;
  end

  assign outputWire = r_out;
  assign slewing    = r_slewing;
  assign state      = r_state;
  assign railHits   = r_rail_hits;

endmodule

// File: doc/output_slew_limiter.md
Name: output_slew_limiter

Overview:
Downstream of the linear-combination stage: takes its saturated 14-bit signed output and drives the DAC path. Limits output rate of change to a programmable step per update tick, and supports freeze (hold) and a controlled ramp to zero on disable. Counts rail hits for host-side loop diagnostics.

Parameters:
WIDTH, 14, sample width (signed); fixes rails at +8191 / -8192
STEP_WIDTH, 13, width of maxStep (unsigned)
PRESCALE_WIDTH, 16, width of update-period prescaler

Ports:
clk64  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
inputWire  input  14  signed target sample from the linear-combination stage
enable  input  1  1 = run loop output; 0 = park (ramp to zero)
hold  input  1  1 = freeze output (while enabled)
maxStep  input  13  unsigned max |change| per tick; 0 = no limit
prescale  input  16  update period minus 1 (0 = tick every cycle)
outputWire  output  14  signed limited output, registered
slewing  output  1  1 when the last applied update was step-clamped
state  output  2  current FSM state (OFF=0, TRACK=1, HOLD=2, PARK=3)
railHits  output  16  saturating count of TRACK updates landing on a rail

Behaviour:
- Reset (async, immediate): outputWire=0, slewing=0, state=OFF, railHits=0, prescaler count=0.
- Prescaler: counter at 0 -> tick asserted that cycle, counter reloads prescale; else decrements. Free-runs in all states. New prescale value takes effect at next reload.
- Step rule on a tick (15-bit signed arithmetic): diff = target - outputWire. maxStep=0 or |diff| <= maxStep -> out = target, slewing=0. Otherwise out = outputWire ± maxStep toward target, slewing=1. Result always lies between old out and target, so no overflow or clamping is needed.
- Update in a cycle uses the current state's rule; the state transition takes effect next cycle. Priority: enable=0 > hold > tick.
- OFF: outputWire held at 0, slewing=0. enable=1 -> TRACK.
- TRACK: on tick apply step rule with target=inputWire. enable=0 -> PARK. hold=1 -> HOLD; no update that cycle even if tick.
- HOLD: output and slewing frozen. enable=0 -> PARK. hold=0 -> TRACK.
- PARK: on tick apply step rule with target=0. Output reaching 0 -> OFF next cycle; already 0 on entry -> OFF on the next cycle. enable=1 -> TRACK, resuming from the current output with no jump.
- Latency: output registered; update visible the cycle after the tick. With prescale=0 and maxStep=0, outputWire = inputWire delayed 1 cycle.
- railHits: increments on a TRACK tick whose resulting output is +8191 or -8192. Saturates at 65535. Cleared only by reset.
- slewing: updated only on applied ticks. Cleared to 0 on entry to OFF.
- Input step mid-slew: the next tick uses the new target. Direction may reverse instantly.
- Reset during PARK/HOLD: immediate OFF with output 0. No ramp.

Test Plan:
- Reset then enable=1, prescale=0, maxStep=0, input=1234 -> state TRACK; output 1234 one cycle after first TRACK tick; slewing=0.
- TRACK, output=0, maxStep=100, prescale=3, input=1000 -> output 100, 200, ... every 4 cycles; final tick 900->1000 with slewing=0 (slewing=1 before it).
- Output=500, hold=1 while input steps to -3000 for 50 cycles -> output stays 500, state HOLD. Release -> slews down by maxStep per tick.
- Output=-450, maxStep=200, enable=0 -> PARK: -250, -50, 0, then state OFF; re-enable at -250 resumes from -250 with no jump.
- maxStep=0, input=8191 for 3 ticks then -8192 for 2 ticks -> railHits=5; preload near 65535 confirms saturation at 65535.
- Assert reset mid-ramp (output=-700, PARK) -> output 0, state OFF, railHits 0 without waiting for a clock edge.
